// File: rtl/rad4_div_if.sv
// Divider request/result bundle: operands and start in, flags and results out.
// master drives start/dividend/divisor and observes busy/done/quotient/remainder/ovf/dz;
// slave is the divider side. Widths follow DIGITS (W = 2*DIGITS, dividend is 2W).
interface rad4_div_if #(
  parameter int DIGITS = 128
);
  localparam int W = 2 * DIGITS;

  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           ovf;
  logic           dz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, ovf, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, ovf, dz
  );
endinterface

// File: rtl/rad4_div.sv
// Iterative radix-4 restoring divider (2W / W -> W quotient, W remainder), 2 quotient bits per enabled cycle.
// Latency: done DIGITS+1 enabled cycles after acceptance; 1 enabled cycle for divide-by-zero / overflow.
// Backpressure: none; start is only taken in IDLE, ignored while busy or in FIN; en=0 freezes everything.
// Ports: clk, rst_n (async active-low), en (clock enable), bus (rad4_div_if.slave: start/operands in,
//        busy/done/quotient/remainder/ovf/dz out).
module rad4_div #(
  parameter int DIGITS = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  rad4_div_if.slave  bus
);
  localparam int W  = 2 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  rReg;      // partial remainder, always < dReg
  logic [W-1:0]  qReg;      // low dividend bits shift out the top, quotient digits shift in the bottom
  logic [W-1:0]  dReg;
  logic [W+1:0]  d3Reg;     // 3*divisor precomputed once so the digit select needs no adder
  logic [CW-1:0] cnt;
  logic          busyReg;
  logic          doneReg;
  logic          ovfReg;
  logic          dzReg;
  logic [W-1:0]  quotReg;
  logic [W-1:0]  remReg;

  logic [W-1:0]  divHi;
  logic [W-1:0]  divLo;
  logic [W+1:0]  divisor3;

  assign divHi    = bus.dividend[2*W-1:W];
  assign divLo    = bus.dividend[W-1:0];
  assign divisor3 = {2'b00, bus.divisor} + {1'b0, bus.divisor, 1'b0};

  // One radix-4 step: three independent compares, then a priority select.
  logic [W+1:0] tVal;
  logic [W+1:0] dExt;
  logic [W+1:0] d2Ext;
  logic         ge1, ge2, ge3;
  logic [1:0]   qDig;
  logic [W-1:0] rNext;

  always_comb begin
    tVal  = {rReg, qReg[W-1:W-2]};
    dExt  = {2'b00, dReg};
    d2Ext = {1'b0, dReg, 1'b0};
    ge1   = (tVal >= dExt);
    ge2   = (tVal >= d2Ext);
    ge3   = (tVal >= d3Reg);
    qDig  = 2'd0;
    rNext = tVal[W-1:0];
    // Because R < D, T < 4D, so the difference always fits in W bits.
    if (ge3) begin
      qDig  = 2'd3;
      rNext = W'(tVal - d3Reg);
    end else if (ge2) begin
      qDig  = 2'd2;
      rNext = W'(tVal - d2Ext);
    end else if (ge1) begin
      qDig  = 2'd1;
      rNext = W'(tVal - dExt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rReg    <= '0;
      qReg    <= '0;
      dReg    <= '0;
      d3Reg   <= '0;
      cnt     <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      ovfReg  <= 1'b0;
      dzReg   <= 1'b0;
      quotReg <= '0;
      remReg  <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          doneReg <= 1'b0;
          if (bus.start) begin
            ovfReg <= 1'b0;
            dzReg  <= 1'b0;
            if (bus.divisor == '0) begin
              dzReg   <= 1'b1;
              quotReg <= '1;
              remReg  <= divHi;
              state   <= FIN;
            end else if (divHi >= bus.divisor) begin
              // Quotient would need more than W bits.
              ovfReg  <= 1'b1;
              quotReg <= '1;
              remReg  <= '0;
              state   <= FIN;
            end else begin
              rReg    <= divHi;
              qReg    <= divLo;
              dReg    <= bus.divisor;
              d3Reg   <= divisor3;
              cnt     <= CW'(DIGITS - 1);
              busyReg <= 1'b1;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          rReg <= rNext;
          qReg <= {qReg[W-3:0], qDig};
          if (cnt == '0) begin
            // busy covers exactly the DIGITS iteration cycles.
            busyReg <= 1'b0;
            state   <= FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIN: begin
          // Exception results were already written at acceptance.
          if (!ovfReg && !dzReg) begin
            quotReg <= qReg;
            remReg  <= rReg;
          end
          doneReg <= 1'b1;
          busyReg <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busyReg;
  assign bus.done      = doneReg;
  assign bus.ovf       = ovfReg;
  assign bus.dz        = dzReg;
  assign bus.quotient  = quotReg;
  assign bus.remainder = remReg;
endmodule

// File: tb/tb_rad4_div.sv
// Directed checks of rad4_div at DIGITS=4 plus random identity checks at DIGITS=128.
// Inputs are driven and outputs sampled on the falling edge.
module tb_rad4_div;
  logic clk;
  logic rst_n;
  logic en;

  int checkCnt = 0;
  int failCnt  = 0;

  rad4_div_if #(.DIGITS(4))   s ();
  rad4_div_if #(.DIGITS(128)) b ();

  rad4_div #(.DIGITS(4))   dutS (.clk(clk), .rst_n(rst_n), .en(en), .bus(s));
  rad4_div #(.DIGITS(128)) dutB (.clk(clk), .rst_n(rst_n), .en(en), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checkCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge right after the acceptance edge.
  task automatic startS(input logic [15:0] dvd, input logic [7:0] dvs);
    s.start    = 1'b1;
    s.dividend = dvd;
    s.divisor  = dvs;
    @(negedge clk);
    s.start    = 1'b0;
    s.dividend = 16'hDEAD;
    s.divisor  = 8'h00;
  endtask

  // Counts clock edges until done is seen, and how many sampled cycles had busy high.
  task automatic waitS(input string tag, input int limit, output int cyc, output int busyCyc);
    cyc     = 0;
    busyCyc = 0;
    while (!s.done && cyc < limit) begin
      if (s.busy) busyCyc++;
      @(negedge clk);
      cyc++;
    end
    if (!s.done) chk({tag, "_timeout"}, s.done, 1);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], $urandom()};
    return r;
  endfunction

  int cyc, bc, n;
  logic [511:0] tmp, dvd, prod;
  logic [255:0] dvs, hi;

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    s.start    = 1'b0;
    s.dividend = '0;
    s.divisor  = '0;
    b.start    = 1'b0;
    b.dividend = '0;
    b.divisor  = '0;

    repeat (2) @(negedge clk);
    chk("reset_outs", {s.busy, s.done, s.ovf, s.dz, s.quotient, s.remainder}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x1234 / 0x56 = 0x36 rem 0x10
    startS(16'h1234, 8'h56);
    waitS("t1", 20, cyc, bc);
    chk("t1_latency", cyc, 5);
    chk("t1_busy_cycles", bc, 4);
    chk("t1_quot", s.quotient, 8'h36);
    chk("t1_rem", s.remainder, 8'h10);
    chk("t1_flags", {s.ovf, s.dz}, 2'b00);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_done_hold_en_low", s.done, 1);
    en = 1'b1;
    @(negedge clk);
    chk("t1_done_one_cycle", s.done, 0);

    // Largest in-range quotient: 0xFEFF / 0xFF = 0xFF rem 0xFE
    startS(16'hFEFF, 8'hFF);
    waitS("t2", 20, cyc, bc);
    chk("t2_quot", s.quotient, 8'hFF);
    chk("t2_rem", s.remainder, 8'hFE);
    chk("t2_flags", {s.ovf, s.dz}, 2'b00);

    // Divide by zero, started in the same cycle done is high
    startS(16'hABCD, 8'h00);
    chk("t3_done_drop", s.done, 0);
    chk("t3_no_busy", s.busy, 0);
    waitS("t3", 20, cyc, bc);
    chk("t3_latency", cyc, 1);
    chk("t3_busy_cycles", bc, 0);
    chk("t3_flags", {s.ovf, s.dz}, 2'b01);
    chk("t3_quot", s.quotient, 8'hFF);
    chk("t3_rem", s.remainder, 8'hAB);

    // Overflow: high half equals divisor
    startS(16'h5000, 8'h50);
    waitS("t4", 20, cyc, bc);
    chk("t4_latency", cyc, 1);
    chk("t4_flags", {s.ovf, s.dz}, 2'b10);
    chk("t4_quot", s.quotient, 8'hFF);
    chk("t4_rem", s.remainder, 8'h00);

    // en low 3 cycles mid-run and a start pulse while busy
    startS(16'h1234, 8'h56);
    s.start    = 1'b1;
    s.dividend = 16'h0001;
    s.divisor  = 8'h01;
    @(negedge clk);
    s.start = 1'b0;
    en      = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    waitS("t5", 20, n, bc);
    chk("t5_latency", n + 4, 8);
    chk("t5_quot", s.quotient, 8'h36);
    chk("t5_rem", s.remainder, 8'h10);
    @(negedge clk);
    chk("t5_second_start_ignored", {s.busy, s.done}, 2'b00);

    // Reset mid-run, then a fresh division
    startS(16'h1234, 8'h56);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_outs", {s.busy, s.done, s.ovf, s.dz, s.quotient, s.remainder}, 0);
    repeat (6) @(negedge clk);
    chk("t6_no_done_in_reset", s.done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_after_release", {s.busy, s.done}, 2'b00);
    startS(16'h00FF, 8'h10);
    waitS("t6", 20, cyc, bc);
    chk("t6_latency", cyc, 5);
    chk("t6_quot", s.quotient, 8'h0F);
    chk("t6_rem", s.remainder, 8'h0F);

    // Random full-width vectors, high half kept below the divisor
    for (int v = 0; v < 200; v++) begin
      tmp = rnd512();
      dvs = tmp[255:0] >> $urandom_range(0, 250);
      if (dvs == '0) dvs = 256'd1;
      tmp = rnd512();
      hi  = tmp[511:256] % dvs;
      dvd = {hi, tmp[255:0]};
      b.start    = 1'b1;
      b.dividend = dvd;
      b.divisor  = dvs;
      @(negedge clk);
      b.start = 1'b0;
      cyc = 0;
      while (!b.done && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      if (!b.done) chk("rnd_timeout", b.done, 1);
      prod = {256'b0, b.quotient} * {256'b0, dvs} + {256'b0, b.remainder};
      chk("rnd_identity", prod, dvd);
      chk("rnd_rem_lt_div", (b.remainder < dvs), 1);
      chk("rnd_flags", {b.ovf, b.dz}, 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
    $finish;
  end
endmodule
